// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR coefficient loader.
// Optional feature macro: FIR_COEF_SYM_EN (symmetric half-frame loading).
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        PEND  = 2'd3
    } coef_state_t;

    // Number of beats in a well-formed coefficient frame.
    function automatic int coef_frame_len(input int ntaps);
`ifdef FIR_COEF_SYM_EN
        return (ntaps + 1) / 2;
`else
        return ntaps;
`endif
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient register banks for the FIR tap chain.
// Ports: i_clk, i_reset (sync, high), i_wr/i_idx/i_data shadow write,
//        i_swap copies shadow to active, o_taps flattened active bank.
//        FIR_COEF_SYM_EN mirrors each write to tap NTAPS-1-idx.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int TW    = 16,
    parameter int IW    = $clog2(NTAPS)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wr,
    input  logic [IW-1:0]       i_idx,
    input  logic [TW-1:0]       i_data,
    input  logic                i_swap,
    output logic [NTAPS*TW-1:0] o_taps
);

    logic [TW-1:0] shadow [NTAPS];
    logic [TW-1:0] active [NTAPS];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
`ifdef FIR_COEF_SYM_EN
                // Centre tap of an odd chain matches both terms: one write.
                if (i_wr && ((i_idx == IW'(k)) ||
                             (i_idx == IW'(NTAPS - 1 - k))))
                    shadow[k] <= i_data;
`else
                if (i_wr && (i_idx == IW'(k)))
                    shadow[k] <= i_data;
`endif
                if (i_swap)
                    active[k] <= shadow[k];
            end
        end
    end

    for (genvar k = 0; k < NTAPS; k++) begin : g_flat
        assign o_taps[k*TW +: TW] = active[k];
    end

endmodule

// File: rtl/fir_coef_loader.sv
// Framed valid/ready coefficient loader with sample-aligned bank swap.
// Ports: i_clk, i_reset, i_ce, i_cvalid/o_cready/i_coef/i_clast beats,
//        o_taps active bank, o_swap/o_err pulses, o_busy. Macro: FIR_COEF_SYM_EN.
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int TW    = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_ce,
    input  logic                i_cvalid,
    output logic                o_cready,
    input  logic [TW-1:0]       i_coef,
    input  logic                i_clast,
    output logic [NTAPS*TW-1:0] o_taps,
    output logic                o_swap,
    output logic                o_err,
    output logic                o_busy
);

    localparam int            IW   = $clog2(NTAPS);
    localparam int            L    = coef_frame_len(NTAPS);
    localparam logic [IW-1:0] LAST = IW'(L - 1);

    coef_state_t   state;
    logic [IW-1:0] idx;
    logic [IW-1:0] cur_idx;
    logic          accept;
    logic          wr;
    logic          swap;

    assign o_cready = !i_reset && (state != PEND);
    assign o_busy   = (state != IDLE);
    assign accept   = i_cvalid && o_cready;
    // In IDLE the incoming beat is always tap 0, whatever idx holds.
    assign cur_idx  = (state == IDLE) ? '0 : idx;
    assign wr       = accept && ((state == IDLE) || (state == LOAD));
    assign swap     = (state == PEND) && i_ce;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            idx    <= '0;
            o_swap <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            o_swap <= 1'b0;
            o_err  <= 1'b0;
            unique case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (cur_idx == LAST) begin
                            // idx parks at 0 so it never wraps.
                            idx <= '0;
                            if (i_clast) begin
                                state <= PEND;
                            end else begin
                                o_err <= 1'b1;
                                state <= DRAIN;
                            end
                        end else if (i_clast) begin
                            idx   <= '0;
                            o_err <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx   <= cur_idx + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && i_clast)
                        state <= IDLE;
                end
                PEND: begin
                    if (i_ce) begin
                        o_swap <= 1'b1;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    fir_coef_bank #(
        .NTAPS (NTAPS),
        .TW    (TW),
        .IW    (IW)
    ) u_bank (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr    (wr),
        .i_idx   (cur_idx),
        .i_data  (i_coef),
        .i_swap  (swap),
        .o_taps  (o_taps)
    );

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed vector bench for fir_coef_loader with NTAPS=4, TW=16.
// Build with FIR_COEF_SYM_EN defined to exercise the symmetric vectors.
module tb_fir_coef_loader;
    import fir_pkg::*;

    localparam int NT = 4;
    localparam int W  = 16;
    localparam int L  = coef_frame_len(NT);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic          cvalid = 1'b0;
    logic          cready;
    logic [W-1:0]  coef = '0;
    logic          clast = 1'b0;
    logic [NT*W-1:0] taps;
    logic          swp;
    logic          err;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fir_coef_loader #(.NTAPS(NT), .TW(W)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_ce     (ce),
        .i_cvalid (cvalid),
        .o_cready (cready),
        .i_coef   (coef),
        .i_clast  (clast),
        .o_taps   (taps),
        .o_swap   (swp),
        .o_err    (err),
        .o_busy   (busy)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [15:0] coef;
        logic        last;
        logic        ce;
        logic        cr;
        logic        busy;
        logic        sw;
        logic        er;
        logic [63:0] taps;
    } vec_t;

    vec_t tbl [0:63];
    int   n = 0;

    task automatic add(input logic r, input logic v, input logic [15:0] c,
                       input logic l, input logic e, input logic cr,
                       input logic b, input logic s, input logic er,
                       input logic [63:0] t);
        tbl[n].rst  = r;
        tbl[n].v    = v;
        tbl[n].coef = c;
        tbl[n].last = l;
        tbl[n].ce   = e;
        tbl[n].cr   = cr;
        tbl[n].busy = b;
        tbl[n].sw   = s;
        tbl[n].er   = er;
        tbl[n].taps = t;
        n++;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] c, input logic l);
        cvalid = 1'b1;
        coef   = c;
        clast  = l;
        tick();
        cvalid = 1'b0;
        clast  = 1'b0;
    endtask

    task automatic wait_swap(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (swp) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0][15:0] c);
        logic [63:0] t;
        t = '0;
        for (int i = 0; i < L; i++) begin
            t[i*16 +: 16] = c[i];
`ifdef FIR_COEF_SYM_EN
            t[(NT-1-i)*16 +: 16] = c[i];
`endif
        end
        return t;
    endfunction

    initial begin
        logic [63:0] z;
        logic [3:0][15:0] ca;
        logic [3:0][15:0] cb;
        logic ok;
        z = '0;

`ifdef FIR_COEF_SYM_EN
        add(1, 0, 16'h0000, 0, 1, 0, 0, 0, 0, z);
        add(0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, z);
        add(0, 1, 16'h0010, 0, 1, 1, 1, 0, 0, z);
        add(0, 1, 16'h0020, 1, 1, 0, 1, 0, 0, z);
        add(0, 0, 16'h0000, 0, 1, 1, 0, 1, 0, 64'h0010_0020_0020_0010);
        add(0, 1, 16'h0001, 0, 1, 1, 1, 0, 0, 64'h0010_0020_0020_0010);
        add(0, 1, 16'h0002, 0, 1, 1, 1, 0, 1, 64'h0010_0020_0020_0010);
        add(0, 1, 16'h0003, 1, 1, 1, 0, 0, 0, 64'h0010_0020_0020_0010);
        add(0, 1, 16'h0005, 1, 1, 1, 0, 0, 1, 64'h0010_0020_0020_0010);
        add(0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 64'h0010_0020_0020_0010);
`else
        // nominal load, ce held high
        add(1, 0, 16'h0000, 0, 1, 0, 0, 0, 0, z);
        add(0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, z);
        add(0, 1, 16'h0001, 0, 1, 1, 1, 0, 0, z);
        add(0, 1, 16'h0002, 0, 1, 1, 1, 0, 0, z);
        add(0, 1, 16'hFFFF, 0, 1, 1, 1, 0, 0, z);
        add(0, 1, 16'h7FFF, 1, 1, 0, 1, 0, 0, z);
        add(0, 0, 16'h0000, 0, 1, 1, 0, 1, 0, 64'h7FFF_FFFF_0002_0001);
        add(0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 64'h7FFF_FFFF_0002_0001);
        // swap gated by ce for 10 cycles; offered beats are refused
        add(0, 1, 16'h0011, 0, 0, 1, 1, 0, 0, 64'h7FFF_FFFF_0002_0001);
        add(0, 1, 16'h0022, 0, 0, 1, 1, 0, 0, 64'h7FFF_FFFF_0002_0001);
        add(0, 1, 16'h0033, 0, 0, 1, 1, 0, 0, 64'h7FFF_FFFF_0002_0001);
        add(0, 1, 16'h0044, 1, 0, 0, 1, 0, 0, 64'h7FFF_FFFF_0002_0001);
        for (int k = 0; k < 10; k++)
            add(0, 1, 16'hDEAD, 0, 0, 0, 1, 0, 0, 64'h7FFF_FFFF_0002_0001);
        add(0, 0, 16'h0000, 0, 1, 1, 0, 1, 0, 64'h0044_0033_0022_0011);
        // short frame
        add(0, 1, 16'hAAAA, 0, 1, 1, 1, 0, 0, 64'h0044_0033_0022_0011);
        add(0, 1, 16'hBBBB, 1, 1, 1, 0, 0, 1, 64'h0044_0033_0022_0011);
        add(0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 64'h0044_0033_0022_0011);
        // long frame then a good frame
        add(0, 1, 16'h0101, 0, 1, 1, 1, 0, 0, 64'h0044_0033_0022_0011);
        add(0, 1, 16'h0202, 0, 1, 1, 1, 0, 0, 64'h0044_0033_0022_0011);
        add(0, 1, 16'h0303, 0, 1, 1, 1, 0, 0, 64'h0044_0033_0022_0011);
        add(0, 1, 16'h0404, 0, 1, 1, 1, 0, 1, 64'h0044_0033_0022_0011);
        add(0, 1, 16'h0505, 0, 1, 1, 1, 0, 0, 64'h0044_0033_0022_0011);
        add(0, 1, 16'h0606, 1, 1, 1, 0, 0, 0, 64'h0044_0033_0022_0011);
        add(0, 1, 16'h1111, 0, 1, 1, 1, 0, 0, 64'h0044_0033_0022_0011);
        add(0, 1, 16'h2222, 0, 1, 1, 1, 0, 0, 64'h0044_0033_0022_0011);
        add(0, 1, 16'h3333, 0, 1, 1, 1, 0, 0, 64'h0044_0033_0022_0011);
        add(0, 1, 16'h4444, 1, 1, 0, 1, 0, 0, 64'h0044_0033_0022_0011);
        add(0, 0, 16'h0000, 0, 1, 1, 0, 1, 0, 64'h4444_3333_2222_1111);
        // reset mid-load, then a clean frame from a fresh index
        add(0, 1, 16'h5555, 0, 1, 1, 1, 0, 0, 64'h4444_3333_2222_1111);
        add(0, 1, 16'h6666, 0, 1, 1, 1, 0, 0, 64'h4444_3333_2222_1111);
        add(1, 0, 16'h0000, 0, 1, 0, 0, 0, 0, z);
        add(0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, z);
        add(0, 1, 16'h000A, 0, 1, 1, 1, 0, 0, z);
        add(0, 1, 16'h000B, 0, 1, 1, 1, 0, 0, z);
        add(0, 1, 16'h000C, 0, 1, 1, 1, 0, 0, z);
        add(0, 1, 16'h000D, 1, 1, 0, 1, 0, 0, z);
        add(0, 0, 16'h0000, 0, 1, 1, 0, 1, 0, 64'h000D_000C_000B_000A);
`endif

        #1;
        for (int i = 0; i < n; i++) begin
            rst    = tbl[i].rst;
            cvalid = tbl[i].v;
            coef   = tbl[i].coef;
            clast  = tbl[i].last;
            ce     = tbl[i].ce;
            tick();
            chk($sformatf("v%0d cready", i), 64'(cready), 64'(tbl[i].cr));
            chk($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].busy));
            chk($sformatf("v%0d swap", i), 64'(swp), 64'(tbl[i].sw));
            chk($sformatf("v%0d err", i), 64'(err), 64'(tbl[i].er));
            chk($sformatf("v%0d taps", i), taps, tbl[i].taps);
        end
        rst    = 1'b0;
        cvalid = 1'b0;
        clast  = 1'b0;

        // back-to-back frames: next frame starts right after the swap edge
        ca = {16'h1004, 16'h1003, 16'h1002, 16'h1001};
        cb = {16'h2004, 16'h2003, 16'h2002, 16'h2001};
        ce = 1'b1;
        for (int i = 0; i < L; i++)
            beat(ca[i], i == L - 1);
        wait_swap(ok);
        chk("b2b swap A", 64'(ok), 64'd1);
        chk("b2b taps A", taps, model(ca));
        for (int i = 0; i < L; i++)
            beat(cb[i], i == L - 1);
        chk("b2b pend B", 64'(busy & ~cready), 64'd1);
        wait_swap(ok);
        chk("b2b swap B", 64'(ok), 64'd1);
        chk("b2b taps B", taps, model(cb));

        // reset while a complete frame waits for ce
        ce = 1'b0;
        for (int i = 0; i < L; i++)
            beat(ca[i], i == L - 1);
        chk("pend cready", 64'(cready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("pend rst taps", taps, z);
        ce = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            ok = ok | swp;
        end
        chk("pend rst noswap", 64'(ok), 64'd0);
        chk("pend rst busy", 64'(busy), 64'd0);
        chk("pend rst taps2", taps, z);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
